// File: rtl/key_dac_ctrl_pkg.sv
// Shared constants for the key-driven two-channel DAC setpoint controller:
// code width, key bit positions and write-scheduler state encodings.
package key_dac_ctrl_pkg;

    localparam int DAC_DW = 12;

    localparam int INC = 0;
    localparam int DEC = 1;
    localparam int SEL = 2;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_INIT_A = 2'd0;
    localparam logic [1:0] ST_INIT_B = 2'd1;
    localparam logic [1:0] ST_IDLE   = 2'd2;
    localparam logic [1:0] ST_REQ    = 2'd3;

endpackage

// File: rtl/key_dac_ctrl_timer.sv
// Hold / auto-repeat timer: after start, pulses once HOLD_CYC cycles later and
// then every RPT_CYC cycles until clear.
module key_repeat_timer #(
    parameter int HOLD_CYC = 25_000_000,
    parameter int RPT_CYC  = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic clear_i,
    output logic step_o
);

    localparam int MAXC = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    logic          run_q, run_d;
    logic          rpt_q, rpt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] limit_m1;

    assign limit_m1 = rpt_q ? CW'(RPT_CYC - 1) : CW'(HOLD_CYC - 1);
    assign step_o   = run_q && (cnt_q == limit_m1);

    always_comb begin
        run_d = run_q;
        rpt_d = rpt_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            run_d = 1'b0;
            rpt_d = 1'b0;
            cnt_d = '0;
        end else if (start_i) begin
            run_d = 1'b1;
            rpt_d = 1'b0;
            cnt_d = '0;
        end else if (run_q) begin
            // After the first (hold) pulse the period switches to RPT_CYC.
            if (step_o) begin
                cnt_d = '0;
                rpt_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= 1'b0;
            rpt_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            rpt_q <= rpt_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/key_dac_ctrl.sv
// Key-driven two-channel DAC setpoint controller: saturating inc/dec with
// auto-repeat, channel select, and a dirty-bit write scheduler to the DAC driver.
module key_dac_ctrl
    import key_dac_ctrl_pkg::*;
#(
    parameter int DW        = DAC_DW,
    parameter int STEP      = 16,
    parameter int INIT_CODE = 2048,
    parameter int HOLD_CYC  = 25_000_000,
    parameter int RPT_CYC   = 5_000_000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    key_flag,
    input  logic [2:0]    key_state,
    input  logic          dac_ack,
    output logic          dac_req,
    output logic          dac_ch,
    output logic [DW-1:0] dac_data,
    output logic          sel_ch,
    output logic [DW-1:0] code_a,
    output logic [DW-1:0] code_b,
    output logic [1:0]    dbg_state_o
);

    localparam logic [DW-1:0] INIT_V = DW'(INIT_CODE);
    localparam logic [DW:0]   STEP_V = (DW + 1)'(STEP);
    localparam logic [DW:0]   MAX_V  = {1'b0, {DW{1'b1}}};

    state_t        state_q, state_d;
    logic [DW-1:0] code_a_q, code_a_d;
    logic [DW-1:0] code_b_q, code_b_d;
    logic [1:0]    dirty_q, dirty_d;
    logic          sel_q, sel_d;
    logic          held_q, held_d;
    logic          held_dec_q, held_dec_d;
    logic          dac_ch_q, dac_ch_d;
    logic [DW-1:0] dac_data_q, dac_data_d;

    logic [2:0]    key_press, key_rel;
    logic          new_press, held_rel, rpt_step;
    logic          step_en, step_dec, changed;
    logic [DW-1:0] cur_code, nxt_code;
    logic [DW:0]   sum_w, diff_w;

    assign key_press = key_flag & ~key_state;
    assign key_rel   = key_flag & key_state;

    // Only a lone inc or dec press is accepted, and only when no key is held.
    assign new_press = !held_q && (key_press[INC] ^ key_press[DEC]);
    assign held_rel  = held_q && (held_dec_q ? key_rel[DEC] : key_rel[INC]);
    assign step_en   = new_press || (held_q && rpt_step);
    assign step_dec  = new_press ? key_press[DEC] : held_dec_q;

    key_repeat_timer #(
        .HOLD_CYC (HOLD_CYC),
        .RPT_CYC  (RPT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .start_i (new_press),
        .clear_i (held_rel),
        .step_o  (rpt_step)
    );

    assign cur_code = sel_q ? code_b_q : code_a_q;
    assign sum_w    = {1'b0, cur_code} + STEP_V;
    assign diff_w   = {1'b0, cur_code} - STEP_V;

    always_comb begin
        nxt_code = cur_code;
        if (step_dec) begin
            nxt_code = diff_w[DW] ? '0 : diff_w[DW-1:0];
        end else begin
            nxt_code = (sum_w > MAX_V) ? MAX_V[DW-1:0] : sum_w[DW-1:0];
        end
    end

    assign changed = step_en && (nxt_code != cur_code);

    always_comb begin
        state_d    = state_q;
        code_a_d   = code_a_q;
        code_b_d   = code_b_q;
        dirty_d    = dirty_q;
        sel_d      = sel_q ^ key_press[SEL];
        held_d     = held_q;
        held_dec_d = held_dec_q;
        dac_ch_d   = dac_ch_q;
        dac_data_d = dac_data_q;

        if (new_press) begin
            held_d     = 1'b1;
            held_dec_d = key_press[DEC];
        end else if (held_rel) begin
            held_d     = 1'b0;
            held_dec_d = 1'b0;
        end

        case (state_q)
            ST_INIT_A: begin
                if (dac_ack) begin
                    state_d    = ST_INIT_B;
                    dac_ch_d   = 1'b1;
                    dac_data_d = INIT_V;
                end
            end
            ST_INIT_B: begin
                if (dac_ack) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (dirty_q[0]) begin
                    state_d    = ST_REQ;
                    dac_ch_d   = 1'b0;
                    dac_data_d = code_a_q;
                    dirty_d[0] = 1'b0;
                end else if (dirty_q[1]) begin
                    state_d    = ST_REQ;
                    dac_ch_d   = 1'b1;
                    dac_data_d = code_b_q;
                    dirty_d[1] = 1'b0;
                end
            end
            ST_REQ: begin
                if (dac_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_INIT_A;
        endcase

        // A change in the capture cycle re-marks the channel so the newer code is sent next.
        if (changed) begin
            if (sel_q) begin
                code_b_d   = nxt_code;
                dirty_d[1] = 1'b1;
            end else begin
                code_a_d   = nxt_code;
                dirty_d[0] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT_A;
            code_a_q   <= INIT_V;
            code_b_q   <= INIT_V;
            dirty_q    <= 2'b00;
            sel_q      <= 1'b0;
            held_q     <= 1'b0;
            held_dec_q <= 1'b0;
            dac_ch_q   <= 1'b0;
            dac_data_q <= INIT_V;
        end else begin
            state_q    <= state_d;
            code_a_q   <= code_a_d;
            code_b_q   <= code_b_d;
            dirty_q    <= dirty_d;
            sel_q      <= sel_d;
            held_q     <= held_d;
            held_dec_q <= held_dec_d;
            dac_ch_q   <= dac_ch_d;
            dac_data_q <= dac_data_d;
        end
    end

    assign dac_req     = (state_q != ST_IDLE);
    assign dac_ch      = dac_ch_q;
    assign dac_data    = dac_data_q;
    assign sel_ch      = sel_q;
    assign code_a      = code_a_q;
    assign code_b      = code_b_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_key_dac_ctrl.sv
// Self-checking bench for key_dac_ctrl: key stimulus, an acking DAC driver
// model with an expected-write queue, and per-scenario code checks.
module tb_key_dac_ctrl;
    import key_dac_ctrl_pkg::*;

    localparam int DW   = 12;
    localparam int STEP = 16;
    localparam int INIT = 2048;
    localparam int HOLD = 10;
    localparam int RPT  = 4;
    localparam int CMAX = 4095;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    key_flag = 3'b000;
    logic [2:0]    key_state = 3'b111;
    logic          dac_ack = 1'b0;
    logic          dac_req, dac_ch, sel_ch;
    logic [DW-1:0] dac_data, code_a, code_b;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    key_dac_ctrl #(
        .DW(DW), .STEP(STEP), .INIT_CODE(INIT), .HOLD_CYC(HOLD), .RPT_CYC(RPT)
    ) dut (
        .clk(clk), .rst(rst), .key_flag(key_flag), .key_state(key_state),
        .dac_ack(dac_ack), .dac_req(dac_req), .dac_ch(dac_ch), .dac_data(dac_data),
        .sel_ch(sel_ch), .code_a(code_a), .code_b(code_b), .dbg_state_o(dbg_state)
    );

    int          checks = 0;
    int          errors = 0;
    logic [DW:0] exp_q[$];
    logic [DW:0] obs_q[$];
    bit          ack_en = 1'b0;
    bit          coalesce = 1'b0;
    bit          drv_busy = 1'b0;
    int          ack_delay = 3;
    int          writes = 0;
    int          model_a = INIT;
    int          model_b = INIT;
    bit          model_sel = 1'b0;

    function automatic int step_model(int code, bit dec, int n);
        int c = code;
        for (int i = 0; i < n; i++) begin
            if (dec) c = (c < STEP) ? 0 : c - STEP;
            else     c = (c + STEP > CMAX) ? CMAX : c + STEP;
        end
        return c;
    endfunction

    function automatic int hold_steps(int n);
        return (n >= HOLD) ? 2 + (n - HOLD) / RPT : 1;
    endfunction

    task automatic apply_model(bit dec, int n);
        if (model_sel) model_b = step_model(model_b, dec, n);
        else           model_a = step_model(model_a, dec, n);
    endtask

    // DAC driver model: acks each request after ack_delay cycles.
    initial begin
        logic          cap_ch;
        logic [DW-1:0] cap_data;
        logic [DW:0]   exp;
        bit            stable_ok;
        forever begin
            @(negedge clk);
            if (ack_en && dac_req && !rst) begin
                drv_busy  = 1'b1;
                cap_ch    = dac_ch;
                cap_data  = dac_data;
                stable_ok = 1'b1;
                repeat (ack_delay) begin
                    @(negedge clk);
                    if (dac_req !== 1'b1 || dac_ch !== cap_ch || dac_data !== cap_data)
                        stable_ok = 1'b0;
                end
                checks++;
                if (!stable_ok) begin
                    errors++;
                    $display("FAIL req_stable: ch=%0d data=%0d req=%0d, required held ch=%0d data=%0d",
                             dac_ch, dac_data, dac_req, cap_ch, cap_data);
                end
                dac_ack = 1'b1;
                writes++;
                if (coalesce) begin
                    obs_q.push_back({cap_ch, cap_data});
                end else begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: ch=%0d data=%0d, required no write",
                                 cap_ch, cap_data);
                    end else begin
                        exp = exp_q.pop_front();
                        if ({cap_ch, cap_data} !== exp) begin
                            errors++;
                            $display("FAIL write: ch=%0d data=%0d, required ch=%0d data=%0d",
                                     cap_ch, cap_data, exp[DW], exp[DW-1:0]);
                        end
                    end
                end
                @(negedge clk);
                dac_ack  = 1'b0;
                drv_busy = 1'b0;
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic press(int idx);
        @(negedge clk);
        key_flag[idx]  = 1'b1;
        key_state[idx] = 1'b0;
        @(negedge clk);
        key_flag[idx]  = 1'b0;
    endtask

    task automatic release_key(int idx);
        @(negedge clk);
        key_flag[idx]  = 1'b1;
        key_state[idx] = 1'b1;
        @(negedge clk);
        key_flag[idx]  = 1'b0;
    endtask

    task automatic tap(int idx);
        press(idx);
        release_key(idx);
        if (idx == SEL) model_sel = ~model_sel;
        else            apply_model(idx == DEC, 1);
    endtask

    // Release lands n cycles after the press.
    task automatic hold(int idx, int n);
        press(idx);
        repeat (n - 2) @(negedge clk);
        release_key(idx);
        apply_model(idx == DEC, hold_steps(n));
    endtask

    task automatic wait_idle(string name);
        int quiet = 0;
        int budget = 3000;
        while (quiet < 6 && budget > 0) begin
            @(negedge clk);
            budget--;
            if (!dac_req && !drv_busy) quiet++;
            else quiet = 0;
        end
        checks++;
        if (quiet < 6) begin
            errors++;
            $display("FAIL %s_timeout: dac_req=%0d still active, required idle", name, dac_req);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: %0d writes outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset;
        ack_en    = 1'b0;
        rst       = 1'b1;
        key_flag  = 3'b000;
        key_state = 3'b111;
        repeat (2) @(negedge clk);
        checks++;
        if (dac_req !== 1'b1 || dac_ch !== 1'b0 || dac_data !== DW'(INIT)) begin
            errors++;
            $display("FAIL reset_req: req=%0d ch=%0d data=%0d, required 1 0 %0d",
                     dac_req, dac_ch, dac_data, INIT);
        end
        checks++;
        if (code_a !== DW'(INIT) || code_b !== DW'(INIT) || sel_ch !== 1'b0) begin
            errors++;
            $display("FAIL reset_codes: a=%0d b=%0d sel=%0d, required %0d %0d 0",
                     code_a, code_b, sel_ch, INIT, INIT);
        end
        model_a   = INIT;
        model_b   = INIT;
        model_sel = 1'b0;
        ack_delay = 3;
        exp_q.push_back({1'b0, DW'(INIT)});
        exp_q.push_back({1'b1, DW'(INIT)});
        rst    = 1'b0;
        ack_en = 1'b1;
        wait_idle("init");
        checks++;
        if (dac_req !== 1'b0) begin
            errors++;
            $display("FAIL init_idle: dac_req=%0d, required 0", dac_req);
        end
    endtask

    task automatic test_single_inc;
        ack_delay = $urandom_range(1, 5);
        exp_q.push_back({1'b0, DW'(step_model(model_a, 1'b0, 1))});
        tap(INC);
        wait_idle("single_inc");
        checks++;
        if (code_a !== DW'(model_a) || code_a !== DW'(2064)) begin
            errors++;
            $display("FAIL single_inc_code: code_a=%0d, required %0d", code_a, model_a);
        end
    endtask

    task automatic test_hold;
        test_reset();
        obs_q.delete();
        coalesce  = 1'b1;
        ack_delay = 20;
        hold(INC, 22);
        wait_idle("hold");
        coalesce = 1'b0;
        checks++;
        if (code_a !== DW'(2128) || model_a != 2128) begin
            errors++;
            $display("FAIL hold_code: code_a=%0d, required 2128", code_a);
        end
        checks++;
        if (obs_q.size() < 2 || obs_q.size() > 4) begin
            errors++;
            $display("FAIL hold_coalesce: %0d writes, required 2..4", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== {1'b0, DW'(2064)} || obs_q[obs_q.size()-1] !== {1'b0, DW'(2128)}) begin
                errors++;
                $display("FAIL hold_writes: first=%0h last=%0h, required %0h %0h",
                         obs_q[0], obs_q[obs_q.size()-1], {1'b0, DW'(2064)}, {1'b0, DW'(2128)});
            end
        end
        ack_delay = 3;
    endtask

    task automatic test_saturate;
        int w0;
        tap(SEL);
        obs_q.delete();
        coalesce = 1'b1;
        hold(INC, 600);
        wait_idle("sat_hi");
        checks++;
        if (code_b !== DW'(model_b) || model_b != CMAX || sel_ch !== 1'b1 ||
            obs_q.size() == 0 || obs_q[obs_q.size()-1] !== {1'b1, DW'(CMAX)}) begin
            errors++;
            $display("FAIL sat_hi: code_b=%0d sel=%0d writes=%0d, required 4095 on B",
                     code_b, sel_ch, obs_q.size());
        end
        tap(SEL);
        obs_q.delete();
        hold(DEC, 600);
        wait_idle("sat_lo");
        checks++;
        if (code_a !== DW'(model_a) || model_a != 0 ||
            obs_q.size() == 0 || obs_q[obs_q.size()-1] !== {1'b0, DW'(0)}) begin
            errors++;
            $display("FAIL sat_lo: code_a=%0d writes=%0d, required 0 on A", code_a, obs_q.size());
        end
        coalesce = 1'b0;
        tap(SEL);
        w0 = writes;
        tap(INC);
        wait_idle("sat_nochange");
        checks++;
        if (writes != w0 || code_b !== DW'(CMAX)) begin
            errors++;
            $display("FAIL sat_nochange: code_b=%0d new writes=%0d, required 4095 and 0",
                     code_b, writes - w0);
        end
        tap(SEL);
    endtask

    task automatic test_both_channels;
        ack_delay = 20;
        tap(SEL);
        exp_q.push_back({1'b1, DW'(step_model(model_b, 1'b1, 1))});
        tap(DEC);
        tap(DEC);
        tap(SEL);
        tap(INC);
        exp_q.push_back({1'b0, DW'(model_a)});
        exp_q.push_back({1'b1, DW'(model_b)});
        wait_idle("both");
        checks++;
        if (code_a !== DW'(16) || code_b !== DW'(4063)) begin
            errors++;
            $display("FAIL both_codes: a=%0d b=%0d, required 16 4063", code_a, code_b);
        end
        ack_delay = 3;
        @(negedge clk);
        key_flag  = 3'b011;
        key_state = 3'b100;
        @(negedge clk);
        key_flag  = 3'b000;
        @(negedge clk);
        key_flag  = 3'b011;
        key_state = 3'b111;
        @(negedge clk);
        key_flag  = 3'b000;
        wait_idle("simul");
        checks++;
        if (code_a !== DW'(model_a) || code_b !== DW'(model_b)) begin
            errors++;
            $display("FAIL simul_press: a=%0d b=%0d, required %0d %0d",
                     code_a, code_b, model_a, model_b);
        end
    endtask

    task automatic test_reset_mid;
        ack_en = 1'b0;
        tap(INC);
        repeat (3) @(negedge clk);
        checks++;
        if (dac_req !== 1'b1 || dac_data !== DW'(model_a)) begin
            errors++;
            $display("FAIL mid_pending: req=%0d data=%0d, required 1 %0d", dac_req, dac_data, model_a);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dac_req !== 1'b1 || dac_ch !== 1'b0 || dac_data !== DW'(INIT) ||
            code_a !== DW'(INIT) || code_b !== DW'(INIT)) begin
            errors++;
            $display("FAIL mid_reset: req=%0d ch=%0d data=%0d a=%0d b=%0d, required 1 0 2048 2048 2048",
                     dac_req, dac_ch, dac_data, code_a, code_b);
        end
        test_reset();
    endtask

    initial begin
        test_reset();
        test_single_inc();
        test_hold();
        test_saturate();
        test_both_channels();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_dac_ctrl.md
KEY_DAC_CTRL -- requirements
Module: key_dac_ctrl

Interface
REQ-001 Parameter DW, 12: DAC code width.
REQ-002 Parameter STEP, 16: code increment/decrement per step event.
REQ-003 Parameter INIT_CODE, 2048: code loaded into both channels at reset.
REQ-004 Parameter HOLD_CYC, 25_000_000: clk cycles a key stays pressed before auto-repeat starts.
REQ-005 Parameter RPT_CYC, 5_000_000: clk cycles between auto-repeat steps.
REQ-006 Port clk  input  1  system clock; single clock domain.
REQ-007 Port rst  input  1  reset, asynchronous, active-high.
REQ-008 Port key_flag  input  3  one-cycle debounced key event pulses; bit0 = inc, bit1 = dec, bit2 = channel toggle.
REQ-009 Port key_state  input  3  debounced level qualifying key_flag; 0 = press, 1 = release.
REQ-010 Port dac_ack  input  1  one-cycle pulse from the DAC serial driver: transfer complete.
REQ-011 Port dac_req  output  1  write request to the DAC driver, held until dac_ack.
REQ-012 Port dac_ch  output  1  channel of the pending write; 0 = A, 1 = B.
REQ-013 Port dac_data  output  DW  code of the pending write.
REQ-014 Port sel_ch  output  1  channel currently targeted by inc/dec.
REQ-015 Port code_a, code_b  output  DW each  current setpoint per channel.

Function
REQ-016 A key event is a press when key_flag[i]=1 and key_state[i]=0, and a release when key_flag[i]=1 and key_state[i]=1.
REQ-017 A press on bit2 toggles sel_ch in the next cycle; a release on bit2 has no effect.
REQ-018 An inc/dec press with no inc/dec key held shall apply one step to the sel_ch code in the next cycle and latch that key as the held key.
REQ-019 An inc/dec press while another inc/dec key is held is ignored; simultaneous inc and dec presses in the same cycle are both ignored.
REQ-020 While a key is held: a hold counter counts to HOLD_CYC, then one step is applied and the counter reloads for RPT_CYC, repeating until release.
REQ-021 A release of the held key clears the held key and the counter in the next cycle; a release of a non-held key is ignored.
REQ-022 Steps saturate: inc clamps at 2^DW-1 and dec clamps at 0; the arithmetic uses DW+1 bits.
REQ-023 A step that leaves the code unchanged (already at the limit) sets no dirty bit.
REQ-024 A channel toggle during a hold redirects later repeat steps to the new sel_ch.
REQ-025 Each channel has a dirty bit, set by any code change on that channel.
REQ-026 The scheduler FSM has states INIT_A, INIT_B, IDLE, REQ.
REQ-027 INIT_A/INIT_B: dac_req=1 with INIT_CODE on channel 0 and then channel 1; each state advances on dac_ack; INIT_B goes to IDLE.
REQ-028 IDLE: if any dirty bit is set, go to REQ in the next cycle and pick A when both are dirty, otherwise the dirty channel.
REQ-029 Entering REQ clears the chosen dirty bit and captures dac_ch/dac_data.
REQ-030 dac_data/dac_ch stay stable while dac_req=1.
REQ-031 REQ holds dac_req=1 until dac_ack, then returns to IDLE with dac_req=0 in the next cycle.
REQ-032 Changes during REQ re-set the dirty bit; the write is coalesced to the latest code on the next pass.
REQ-033 Key events during INIT_A/INIT_B update the codes and dirty bits normally.
REQ-034 dac_ack outside REQ/INIT states is ignored.

Reset
REQ-035 On rst, all of the following take effect asynchronously: state=INIT_A, code_a=code_b=INIT_CODE, dirty=0, sel_ch=0, held key none, counter 0, dac_req=1, dac_ch=0, dac_data=INIT_CODE.
REQ-036 A reset mid-transfer abandons the request and restarts initialisation.

Structure
REQ-037 The FSM state encodings, the key index constants (INC=0, DEC=1, SEL=2) and DW go in a shared package.
REQ-038 The hold/auto-repeat timer is one sub-module, key_repeat_timer, with inputs start/clear and a step-pulse output.

Verification (HOLD_CYC=10, RPT_CYC=4, STEP=16)
REQ-039 Reset, ack each request after 3 cycles -> writes (A,2048) then (B,2048), then IDLE with dac_req=0.
REQ-040 Single inc press/release on A -> code_a=2064, one write (A,2064).
REQ-041 Inc held 22 cycles -> steps at press, +10, +14, +18, +22 (5 steps), code_a=2128; writes coalesce while ack is delayed 20 cycles.
REQ-042 code_b=4090, toggle to B, inc press -> code_b=4095; second press -> no change, no write.
REQ-043 Both channels changed in the same window -> A written before B; simultaneous inc+dec press -> no change.
REQ-044 rst asserted while dac_req=1 -> dac_req stays 1, dac_ch=0, dac_data=2048, codes=2048.
